// File: rtl/prom_pkg.sv
// Shared types for the program-ROM access path: response owner tags, arbiter
// FSM states and the default ROM geometry.
package prom_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    localparam int PROM_ADDR_W     = 5;
    localparam int PROM_DATA_W     = 32;
    localparam int PROM_STARVE_MAX = 4;

endpackage

// File: rtl/prom_access_arbiter.sv
// Shares the single-port program ROM between instruction fetch and data loads;
// combinational grant, one registered owner tag, data returned one cycle later.
module prom_access_arbiter
    import prom_pkg::*;
#(
    parameter int ADDR_W     = PROM_ADDR_W,
    parameter int DATA_W     = PROM_DATA_W,
    parameter int STARVE_MAX = PROM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: a requester raises req with a stable addr and holds both until
    // the cycle its gnt is 1; that cycle is the transfer. The response appears as
    // a single-cycle rvalid one cycle later, with no back-pressure on it.
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [1:0]        dbg_state,
    output logic [3:0]        dbg_starve_cnt
);

    localparam logic [1:0] ST_RESET = S_RESET;
    localparam logic [1:0] ST_WARM  = S_WARM;
    localparam logic [1:0] ST_RUN   = S_RUN;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [3:0]        starve_q;
    owner_e            owner_q;
    owner_e            owner_d;
    logic [ADDR_W-1:0] ad_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ld_rdata_q;
    logic              run;
    logic              fetch_forced;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_WARM;
            ST_WARM:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gates every output combinationally so an in-flight response is
    // dropped in the very cycle reset is raised.
    assign run          = (state_q == ST_RUN) && !reset;
    assign fetch_forced = if_req && (starve_q == STARVE_LIM);

    assign ld_gnt    = run && ld_req && !fetch_forced;
    assign if_gnt    = run && if_req && !ld_gnt;
    assign rom_ce    = ld_gnt || if_gnt;
    assign rom_oce   = run;
    assign rom_reset = reset;

    always_comb begin
        rom_ad = ad_q;
        if (reset) begin
            rom_ad = '0;
        end else if (ld_gnt) begin
            rom_ad = ld_addr;
        end else if (if_gnt) begin
            rom_ad = if_addr;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (ld_gnt) begin
            owner_d = OWN_LD;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ad_q    <= '0;
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
            if (rom_ce) begin
                ad_q <= rom_ad;
            end
        end
    end

    // Counts loads granted over a waiting fetch; any fetch grant or an idle
    // fetch port restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!if_req || if_gnt) begin
            starve_q <= '0;
        end else if (ld_gnt && (starve_q < STARVE_LIM)) begin
            starve_q <= starve_q + 4'd1;
        end
    end

    assign if_rvalid = !reset && (owner_q == OWN_IF) && !if_flush;
    assign ld_rvalid = !reset && (owner_q == OWN_LD);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= rom_dout;
            end
            if (ld_rvalid) begin
                ld_rdata_q <= rom_dout;
            end
        end
    end

    assign if_rdata = reset ? '0 : (if_rvalid ? rom_dout : if_rdata_q);
    assign ld_rdata = reset ? '0 : (ld_rvalid ? rom_dout : ld_rdata_q);

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_q;

endmodule
